// File: rtl/cic_pkg.sv
// ---------------------------------------------------------------------------
// cic_pkg : shared helpers and limits for the CIC decimator.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cic_pkg;

  localparam int CIC_N_MIN = 1;
  localparam int CIC_N_MAX = 8;
  localparam int CIC_M_MIN = 1;
  localparam int CIC_M_MAX = 2;

  // Register growth of a Hogenauer CIC: one log2(R*M) per stage on top of the input.
  function automatic int cic_acc_width(input int in_w, input int n, input int r, input int m);
    return in_w + n * $clog2(r * m);
  endfunction

  function automatic logic signed [1:0] map_bit(input logic b);
    return b ? 2'sb01 : 2'sb11;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cic_comb_stage.sv
// ---------------------------------------------------------------------------
// cic_comb_stage : one CIC differentiator with M-deep delay line and an
// optional output register (PIPE). Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cic_comb_stage #(
  parameter int ACC_WIDTH = 50,
  parameter int M         = 1,
  parameter bit PIPE      = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_i,
  input  logic signed [ACC_WIDTH-1:0] data_i,
  output logic                        valid_o,
  output logic signed [ACC_WIDTH-1:0] data_o
);

  logic signed [ACC_WIDTH-1:0] dly_q [M];
  logic signed [ACC_WIDTH-1:0] diff_d;

  assign diff_d = data_i - dly_q[M-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < M; k++) dly_q[k] <= '0;
    end else if (valid_i) begin
      dly_q[0] <= data_i;
      for (int k = 1; k < M; k++) dly_q[k] <= dly_q[k-1];
    end
  end

  generate
    if (PIPE) begin : g_pipe
      logic                        valid_q;
      logic signed [ACC_WIDTH-1:0] data_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else begin
          valid_q <= valid_i;
          if (valid_i) data_q <= diff_d;
        end
      end

      assign valid_o = valid_q;
      assign data_o  = data_q;
    end else begin : g_comb
      assign valid_o = valid_i;
      assign data_o  = diff_d;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/cic_decimator.sv
// ---------------------------------------------------------------------------
// cic_decimator : N-stage Hogenauer CIC decimator, 1-bit stream in, signed
// samples out at 1/R rate. Macro CIC_PIPE_EN registers every comb stage.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cic_decimator
  import cic_pkg::*;
#(
  parameter int N         = 6,
  parameter int R         = 256,
  parameter int M         = 1,
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 50
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        in_bit,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] out_data
);

  localparam int ACC_WIDTH = cic_acc_width(IN_WIDTH, N, R, M);
  localparam int CNT_WIDTH = $clog2(R);
`ifdef CIC_PIPE_EN
  localparam bit PIPE_EN = 1'b1;
`else
  localparam bit PIPE_EN = 1'b0;
`endif

  logic signed [IN_WIDTH-1:0]  x_in;
  logic signed [ACC_WIDTH-1:0] x_ext;
  logic signed [ACC_WIDTH-1:0] integ_q [N];
  logic signed [ACC_WIDTH-1:0] integ_d [N];
  logic [CNT_WIDTH-1:0]        cnt_q;
  logic                        strobe;

  assign x_in   = IN_WIDTH'(map_bit(in_bit));
  assign x_ext  = ACC_WIDTH'(x_in);
  assign strobe = in_valid && (cnt_q == CNT_WIDTH'(R - 1));

  // Each stage adds the previous stage's registered value, not its next value.
  always_comb begin
    integ_d[0] = integ_q[0] + x_ext;
    for (int k = 1; k < N; k++) integ_d[k] = integ_q[k] + integ_q[k-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) integ_q[k] <= '0;
      cnt_q <= '0;
    end else if (in_valid) begin
      for (int k = 0; k < N; k++) integ_q[k] <= integ_d[k];
      cnt_q <= cnt_q + 1'b1;  // R is a power of two, so overflow is the wrap
    end
  end

  logic                        comb_vld [N+1];
  logic signed [ACC_WIDTH-1:0] comb_dat [N+1];

  assign comb_vld[0] = strobe;
  assign comb_dat[0] = integ_q[N-1];

  generate
    for (genvar g = 0; g < N; g++) begin : g_comb
      cic_comb_stage #(
        .ACC_WIDTH (ACC_WIDTH),
        .M         (M),
        .PIPE      (PIPE_EN)
      ) u_comb (
        .clk     (clk),
        .rst     (rst),
        .valid_i (comb_vld[g]),
        .data_i  (comb_dat[g]),
        .valid_o (comb_vld[g+1]),
        .data_o  (comb_dat[g+1])
      );
    end
  endgenerate

`ifdef CIC_PIPE_EN
  assign out_valid = comb_vld[N];
  assign out_data  = comb_dat[N][ACC_WIDTH-1 -: OUT_WIDTH];
`else
  logic                        out_valid_q;
  logic signed [OUT_WIDTH-1:0] out_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= comb_vld[N];
      if (comb_vld[N]) out_data_q <= comb_dat[N][ACC_WIDTH-1 -: OUT_WIDTH];
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cic_decimator.sv
// ---------------------------------------------------------------------------
// tb_cic_decimator : checks a small CIC (N=3,R=8) and the default CIC against
// an impulse-response convolution model. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cic_decimator;

  localparam int N1 = 3, R1 = 8, O1 = 11, ACC1 = 11;
  localparam int N2 = 6, R2 = 256, O2 = 50, ACC2 = 50;
`ifdef CIC_PIPE_EN
  localparam int LAT1 = N1, LAT2 = N2;
`else
  localparam int LAT1 = 1, LAT2 = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic v1 = 1'b0, b1 = 1'b0, v2 = 1'b0, b2 = 1'b0;
  logic          ov1, ov2;
  logic [O1-1:0] od1;
  logic [O2-1:0] od2;

  int     n_chk  = 0;
  int     n_fail = 0;
  longint cyc    = 0;

  typedef struct {
    longint due;
    longint val;
  } exp_t;

  exp_t   eq1[$], eq2[$];
  int     hx1[$], hx2[$];
  longint h1[], h2[];
  longint cap1[$], cap2[$];

  always #5 clk = ~clk;

  cic_decimator #(.N(N1), .R(R1), .M(1), .IN_WIDTH(2), .OUT_WIDTH(O1)) u_small (
    .clk(clk), .rst(rst), .in_valid(v1), .in_bit(b1), .out_valid(ov1), .out_data(od1)
  );

  cic_decimator u_dflt (
    .clk(clk), .rst(rst), .in_valid(v2), .in_bit(b2), .out_valid(ov2), .out_data(od2)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Impulse response of the CIC: an R*M boxcar convolved with itself N times.
  function automatic void build_h(input int n, input int l, output longint h[]);
    longint t[];
    h = new[1];
    h[0] = 1;
    for (int s = 0; s < n; s++) begin
      t = new[h.size() + l - 1];
      foreach (t[i]) t[i] = 0;
      foreach (h[i]) for (int j = 0; j < l; j++) t[i+j] += h[i];
      h = t;
    end
  endfunction

  // Output at input-sample n: the integrators contribute n lag samples of delay.
  function automatic longint model_y(input int hx[$], input longint h[], input int n,
                                     input int lag, input int acc, input int ow);
    longint y = 0;
    int     idx;
    foreach (h[j]) begin
      idx = n - lag - j;
      if (idx < 0) break;
      y += h[j] * longint'(hx[idx]);
    end
    y = (y <<< (64 - acc)) >>> (64 - ow);
    return y;
  endfunction

  function automatic longint cap_at(input longint q[$], input int i);
    return (q.size() > i) ? q[i] : 64'sh7fff_ffff_ffff_ffff;
  endfunction

  // Model update on posedge, compare on negedge.
  initial begin
    exp_t e;
    logic ev;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        hx1.delete(); hx2.delete(); eq1.delete(); eq2.delete();
      end else begin
        if (v1) begin
          hx1.push_back(b1 ? 1 : -1);
          if (hx1.size() % R1 == 0) begin
            e.due = cyc + LAT1 - 1;
            e.val = model_y(hx1, h1, hx1.size() - 1, N1, ACC1, O1);
            eq1.push_back(e);
          end
        end
        if (v2) begin
          hx2.push_back(b2 ? 1 : -1);
          if (hx2.size() % R2 == 0) begin
            e.due = cyc + LAT2 - 1;
            e.val = model_y(hx2, h2, hx2.size() - 1, N2, ACC2, O2);
            eq2.push_back(e);
          end
        end
      end
      @(negedge clk);
      if (rst) begin
        chk("rst_valid1", longint'(ov1), 0);
        chk("rst_data1", longint'($signed(od1)), 0);
        chk("rst_valid2", longint'(ov2), 0);
        chk("rst_data2", longint'($signed(od2)), 0);
      end else begin
        ev = (eq1.size() > 0) && (eq1[0].due == cyc);
        chk("valid1", longint'(ov1), longint'(ev));
        if (ev) begin
          chk("data1", longint'($signed(od1)), eq1[0].val);
          cap1.push_back(longint'($signed(od1)));
          void'(eq1.pop_front());
        end
        ev = (eq2.size() > 0) && (eq2[0].due == cyc);
        chk("valid2", longint'(ov2), longint'(ev));
        if (ev) begin
          chk("data2", longint'($signed(od2)), eq2[0].val);
          cap2.push_back(longint'($signed(od2)));
          void'(eq2.pop_front());
        end
      end
    end
  end

  task automatic tick(input logic a_v, input logic a_b, input logic c_v, input logic c_b);
    @(posedge clk);
    #2;
    v1 = a_v; b1 = a_b; v2 = c_v; b2 = c_b;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1; v1 = 1'b0; v2 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    cap1.delete(); cap2.delete();
  endtask

  task automatic pin_ones(input string nm, input longint sgn);
    chk({nm, "_o1"}, cap_at(cap1, 0), sgn * 35);
    chk({nm, "_o2"}, cap_at(cap1, 1), sgn * 350);
    chk({nm, "_o3"}, cap_at(cap1, 2), sgn * 511);
    chk({nm, "_o5"}, cap_at(cap1, 4), sgn * 512);
    chk({nm, "_o6"}, cap_at(cap1, 5), sgn * 512);
  endtask

  initial begin
    int     ones8[$];
    int     nv;
    int     guard;
    longint fs;

    build_h(N1, R1, h1);
    build_h(N2, R2, h2);
    chk("h1_len", h1.size(), 22);
    chk("h1_mid", h1[10], 48);
    for (int i = 0; i < 8; i++) ones8.push_back(1);
    chk("model_pin", model_y(ones8, h1, 7, N1, ACC1, O1), 35);

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // all ones, in_valid every cycle
    for (int i = 0; i < 48; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (6) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_count", cap1.size(), 6);
    pin_ones("t1", 1);

    // all zeros
    do_reset();
    for (int i = 0; i < 48; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (6) tick(1'b0, 1'b0, 1'b0, 1'b0);
    pin_ones("t2z", -1);

    // alternating 1/0
    do_reset();
    for (int i = 0; i < 48; i++) tick(1'b1, (i % 2 == 0), 1'b0, 1'b0);
    repeat (6) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2a_o5", cap_at(cap1, 4), 0);
    chk("t2a_o6", cap_at(cap1, 5), 0);

    // all ones with gapped in_valid
    do_reset();
    nv = 0;
    guard = 0;
    while (nv < 48 && guard < 2000) begin
      guard++;
      if ($urandom_range(0, 9) < 3) begin
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        nv++;
      end else begin
        tick(1'b0, 1'b1, 1'b0, 1'b0);
      end
    end
    repeat (6) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_pulses", nv, 48);
    chk("t3_count", cap1.size(), 6);
    pin_ones("t3", 1);

    // reset between strobes
    do_reset();
    for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t4_pre_count", cap1.size(), 2);
    do_reset();
    for (int i = 0; i < 16; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (6) tick(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_count", cap1.size(), 2);
    chk("t4_o1", cap_at(cap1, 0), 35);
    chk("t4_o2", cap_at(cap1, 1), 350);

    // default parameters: random bits, then full-scale ones
    do_reset();
    for (int i = 0; i < 6 * R2; i++) tick(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 9 * R2; i++) tick(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (10) tick(1'b0, 1'b0, 1'b0, 1'b0);
    fs = 64'sd1 <<< 48;
    chk("t5_count", cap2.size(), 15);
    chk("t5_fullscale", cap_at(cap2, 14), fs);
    chk("t5_fullscale_prev", cap_at(cap2, 13), fs);

    chk("drain1", eq1.size(), 0);
    chk("drain2", eq2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
